// File: rtl/snake_step_scheduler_pkg.sv
// Shared definitions for the greedy-snake design: game status encoding,
// scheduler state enum, level/period widths and the speed-curve helper.
package snake_pkg;

   localparam int LEVEL_W  = 4;
   localparam int PERIOD_W = 24;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   localparam logic [1:0] GS_START   = 2'd0;
   localparam logic [1:0] GS_PLAY    = 2'd1;
   localparam logic [1:0] GS_DIE     = 2'd2;
   localparam logic [1:0] GS_RESTART = 2'd3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      MOVE      = 3'd2,
      CHECK     = 3'd3,
      DEAD      = 3'd4
   } sched_state_t;

   // The underflow test comes before the floor comparison so a small period never wraps.
   function automatic logic [PERIOD_W-1:0] next_period(
      input logic [PERIOD_W-1:0] cur,
      input logic [PERIOD_W-1:0] dec,
      input logic [PERIOD_W-1:0] floor_val
   );
      if ((cur >= dec) && ((cur - dec) >= floor_val))
         return cur - dec;
      else
         return floor_val;
   endfunction

endpackage

// File: rtl/snake_step_scheduler_if.sv
// Request/done handshake between the step scheduler and the snake datapath
// (movement, apple and collision logic).
interface snake_step_scheduler_if;
   import snake_pkg::*;

   logic move_req;
   logic move_done;
   logic chk_req;
   logic chk_done;
   logic hit;
   logic grow;

   modport master (
      output move_req,
      output chk_req,
      input  move_done,
      input  chk_done,
      input  hit,
      input  grow
   );

   modport slave (
      input  move_req,
      input  chk_req,
      output move_done,
      output chk_done,
      output hit,
      output grow
   );

endinterface

// File: rtl/snake_step_scheduler_step_timer.sv
// Loadable tick down-counter with freeze, plus the single-entry pending tick
// and sticky overrun flag for ticks that expire while a step is running.
module step_timer
   import snake_pkg::*;
#(
   parameter int W = PERIOD_W
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         run,
   input  logic         freeze,
   input  logic         in_step,
   input  logic         clr_pending,
   input  logic         clr_overrun,
   input  logic [W-1:0] period,
   output logic         expire,
   output logic         pending,
   output logic         overrun
);

   logic [W-1:0] cnt;
   logic         active;

   // Loading P and expiring on the last count gives exactly P cycles per tick.
   assign active = run && !freeze;
   assign expire = active && (cnt <= W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (load || expire)
         cnt <= period;
      else if (active)
         cnt <= cnt - W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (clr_pending)
            pending <= 1'b0;
         else if (expire && in_step)
            pending <= 1'b1;
         if (clr_overrun)
            overrun <= 1'b0;
         else if (expire && in_step)
            overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/snake_step_scheduler.sv
// Game-step sequencer: tick generation, ordered move/check phases and speed curve.
// Optional macro SNAKE_PAUSE_EN adds a pause input that freezes the tick in WAIT_TICK.
module snake_step_scheduler
   import snake_pkg::*;
#(
   parameter int BASE_PERIOD      = 12_500_000,
   parameter int PERIOD_DEC       = 1_250_000,
   parameter int MIN_PERIOD       = 3_125_000,
   parameter int APPLES_PER_LEVEL = 5
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         game_status,
`ifdef SNAKE_PAUSE_EN
   input  logic               pause,
`endif
   snake_step_scheduler_if.master bus,
   output logic               die_pulse,
   output logic               add_cube,
   output logic [LEVEL_W-1:0] level,
   output logic [15:0]        step_cnt,
   output logic               overrun
);

   localparam logic [PERIOD_W-1:0] BASE_P     = PERIOD_W'(BASE_PERIOD);
   localparam logic [PERIOD_W-1:0] DEC_P      = PERIOD_W'(PERIOD_DEC);
   localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
   localparam logic [7:0]          APPLE_LAST = 8'(APPLES_PER_LEVEL - 1);

   sched_state_t        state, state_next;
   logic [PERIOD_W-1:0] period;
   logic [7:0]          apples;

   logic playing;
   logic t_load, t_run, t_freeze, t_in_step, t_clr_pending, t_clr_overrun;
   logic t_expire, t_pending;
   logic start, do_step, do_die, do_restart;

   assign playing = (game_status == GS_PLAY);

`ifdef SNAKE_PAUSE_EN
   assign t_freeze = pause && (state == WAIT_TICK);
`else
   assign t_freeze = 1'b0;
`endif

   assign t_run         = (state == WAIT_TICK) || (state == MOVE) || (state == CHECK);
   assign t_in_step     = (state == MOVE) || (state == CHECK);
   assign bus.move_req  = (state == MOVE);
   assign bus.chk_req   = (state == CHECK);

   step_timer #(.W(PERIOD_W)) u_timer (
      .clk         (clk),
      .rst         (rst),
      .load        (t_load),
      .run         (t_run),
      .freeze      (t_freeze),
      .in_step     (t_in_step),
      .clr_pending (t_clr_pending),
      .clr_overrun (t_clr_overrun),
      .period      (period),
      .expire      (t_expire),
      .pending     (t_pending),
      .overrun     (overrun)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Leaving PLAY mid-step aborts straight to IDLE without pulses.
   always_comb begin
      state_next    = state;
      t_load        = 1'b0;
      t_clr_pending = 1'b0;
      t_clr_overrun = 1'b0;
      start         = 1'b0;
      do_step       = 1'b0;
      do_die        = 1'b0;
      do_restart    = 1'b0;
      case (state)
         IDLE: begin
            if (playing) begin
               state_next    = WAIT_TICK;
               t_load        = 1'b1;
               t_clr_pending = 1'b1;
               t_clr_overrun = 1'b1;
               start         = 1'b1;
            end
         end
         WAIT_TICK: begin
            if (!playing)
               state_next = IDLE;
            else if (!t_freeze && (t_expire || t_pending)) begin
               state_next    = MOVE;
               t_load        = 1'b1;
               t_clr_pending = 1'b1;
            end
         end
         MOVE: begin
            if (!playing)
               state_next = IDLE;
            else if (bus.move_done)
               state_next = CHECK;
         end
         CHECK: begin
            if (!playing)
               state_next = IDLE;
            else if (bus.chk_done) begin
               if (bus.hit) begin
                  state_next = DEAD;
                  do_die     = 1'b1;
               end else begin
                  state_next = WAIT_TICK;
                  do_step    = 1'b1;
               end
            end
         end
         DEAD: begin
            if ((game_status == GS_RESTART) || (game_status == GS_START)) begin
               state_next = IDLE;
               do_restart = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Speed curve: every APPLES_PER_LEVEL apples bump the level and shorten the period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period    <= BASE_P;
         level     <= '0;
         apples    <= '0;
         step_cnt  <= '0;
         die_pulse <= 1'b0;
         add_cube  <= 1'b0;
      end else begin
         die_pulse <= do_die;
         add_cube  <= 1'b0;
         if (start) begin
            step_cnt <= '0;
            apples   <= '0;
         end
         if (do_restart) begin
            level  <= '0;
            period <= BASE_P;
         end
         if (do_step) begin
            step_cnt <= step_cnt + 16'd1;
            if (bus.grow) begin
               add_cube <= 1'b1;
               if (apples == APPLE_LAST) begin
                  apples <= '0;
                  if (level != LEVEL_MAX)
                     level <= level + LEVEL_W'(1);
                  period <= next_period(period, DEC_P, MIN_P);
               end else begin
                  apples <= apples + 8'd1;
               end
            end
         end
      end
   end

endmodule
